// File: rtl/usb_rx_packet_pkg.sv
// Shared types and CRC constants for the USB receive packet decoder.
package usb_rx_packet_pkg;

  typedef enum logic [3:0] {
    OUT   = 4'h1,
    IN    = 4'h9,
    SOF   = 4'h5,
    SETUP = 4'hD,
    DATA0 = 4'h3,
    DATA1 = 4'hB,
    DATA2 = 4'h7,
    MDATA = 4'hF,
    ACK   = 4'h2,
    NAK   = 4'hA,
    STALL = 4'hE
  } pid_t;

  typedef enum logic [1:0] {
    KIND_TOKEN,
    KIND_DATA,
    KIND_HS,
    KIND_BAD
  } pid_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOK1,
    ST_TOK2,
    ST_END,
    ST_HS,
    ST_DATA,
    ST_ERR
  } state_t;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // SOF shares the two-byte token layout, so it classifies as a token.
  function automatic pid_kind_t pid_kind(input logic [3:0] p);
    pid_kind_t k;
    case (p)
      OUT, IN, SETUP, SOF:         k = KIND_TOKEN;
      DATA0, DATA1, DATA2, MDATA:  k = KIND_DATA;
      ACK, NAK, STALL:             k = KIND_HS;
      default:                     k = KIND_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/usb_rx_packet_crc.sv
// Byte-wide CRC register, bits consumed LSB first with MSB feedback.
module usb_crc #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             en,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (crc_d[WIDTH-1] ^ data[i]) crc_d = (crc_d << 1) ^ POLY;
        else                          crc_d = crc_d << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_rx_packet.sv
// Packet decoder between usb_rx and the SIE: PID/CRC checking, token/SOF
// field extraction and payload forwarding with the CRC16 bytes stripped.
module usb_rx_packet
  import usb_rx_packet_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [10:0] frame,
  output logic        tok_valid,
  output logic        sof_valid,
  output logic        hs_valid,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pkt_done,
  output logic        pkt_ok
);

  localparam int unsigned      CNT_W       = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_PAYLOAD + 3);
  localparam logic [CNT_W-1:0] CNT_FWD_MAX = CNT_W'(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] CNT_LEN_MAX = CNT_W'(MAX_PAYLOAD + 2);
  localparam logic [CNT_W-1:0] CNT_CRC     = CNT_W'(2);

  state_t            state_q, state_d;
  logic              rx_active_q, rx_active_d;
  logic [3:0]        pid_q, pid_d;
  logic [7:0]        b1_q, b1_d;
  logic [2:0]        b2_q, b2_d;
  logic [6:0]        addr_q, addr_d;
  logic [3:0]        endp_q, endp_d;
  logic [10:0]       frame_q, frame_d;
  logic [7:0]        dly0_q, dly0_d;
  logic [7:0]        dly1_q, dly1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        pl_data_q, pl_data_d;
  logic              pl_valid_q, pl_valid_d;
  logic              tok_valid_q, tok_valid_d;
  logic              sof_valid_q, sof_valid_d;
  logic              hs_valid_q, hs_valid_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_ok_q, pkt_ok_d;

  logic              byte_in;
  logic              crc_init;
  logic              crc5_en;
  logic              crc16_en;
  logic [4:0]        crc5;
  logic [15:0]       crc16;

  assign byte_in  = rx_valid && rx_active && !rx_error;
  assign crc_init = (state_q == ST_IDLE);
  assign crc5_en  = byte_in && (state_q == ST_TOK1 || state_q == ST_TOK2);
  assign crc16_en = byte_in && (state_q == ST_DATA);

  usb_crc #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc5_en),
    .data  (rx_data),
    .crc   (crc5)
  );

  usb_crc #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc16_en),
    .data  (rx_data),
    .crc   (crc16)
  );

  always_comb begin
    state_d     = state_q;
    rx_active_d = rx_active;
    pid_d       = pid_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    frame_d     = frame_q;
    dly0_d      = dly0_q;
    dly1_d      = dly1_q;
    cnt_d       = cnt_q;
    pl_data_d   = pl_data_q;
    pl_valid_d  = 1'b0;
    tok_valid_d = 1'b0;
    sof_valid_d = 1'b0;
    hs_valid_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;

    // Entry needs a rising edge so a packet already in flight at reset release is skipped.
    if (state_q == ST_IDLE) begin
      if (rx_active && !rx_active_q) begin
        state_d = ST_PID;
        cnt_d   = '0;
      end
    end else if (!rx_active) begin
      state_d    = ST_IDLE;
      pkt_done_d = 1'b1;
      case (state_q)
        ST_END: begin
          if (crc5 == CRC5_RESIDUAL) begin
            pkt_ok_d = 1'b1;
            if (pid_q == SOF) begin
              sof_valid_d = 1'b1;
              frame_d     = {b2_q, b1_q};
            end else begin
              tok_valid_d = 1'b1;
              addr_d      = b1_q[6:0];
              endp_d      = {b2_q, b1_q[7]};
            end
          end
        end
        ST_HS: begin
          pkt_ok_d   = 1'b1;
          hs_valid_d = 1'b1;
        end
        ST_DATA: begin
          pkt_ok_d = (cnt_q >= CNT_CRC) && (cnt_q <= CNT_LEN_MAX) &&
                     (crc16 == CRC16_RESIDUAL);
        end
        default: ;
      endcase
    end else if (rx_error) begin
      state_d = ST_ERR;
    end else if (rx_valid) begin
      case (state_q)
        ST_PID: begin
          pid_d = rx_data[3:0];
          if (rx_data[3:0] != ~rx_data[7:4]) begin
            state_d = ST_ERR;
          end else begin
            case (pid_kind(rx_data[3:0]))
              KIND_TOKEN: state_d = ST_TOK1;
              KIND_DATA:  state_d = ST_DATA;
              KIND_HS:    state_d = ST_HS;
              default:    state_d = ST_ERR;
            endcase
          end
        end
        ST_TOK1: begin
          b1_d    = rx_data;
          state_d = ST_TOK2;
        end
        ST_TOK2: begin
          b2_d    = rx_data[2:0];
          state_d = ST_END;
        end
        ST_END, ST_HS: state_d = ST_ERR;
        ST_DATA: begin
          // Two-byte delay line keeps the trailing CRC16 bytes from being forwarded.
          if (cnt_q >= CNT_CRC && cnt_q <= CNT_FWD_MAX) begin
            pl_valid_d = 1'b1;
            pl_data_d  = dly1_q;
          end
          dly1_d = dly0_q;
          dly0_d = rx_data;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rx_active_q <= rx_active;
      pid_q       <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      frame_q     <= '0;
      dly0_q      <= '0;
      dly1_q      <= '0;
      cnt_q       <= '0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      tok_valid_q <= 1'b0;
      sof_valid_q <= 1'b0;
      hs_valid_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_active_q <= rx_active_d;
      pid_q       <= pid_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      frame_q     <= frame_d;
      dly0_q      <= dly0_d;
      dly1_q      <= dly1_d;
      cnt_q       <= cnt_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      tok_valid_q <= tok_valid_d;
      sof_valid_q <= sof_valid_d;
      hs_valid_q  <= hs_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
    end
  end

  assign pid       = pid_q;
  assign addr      = addr_q;
  assign endp      = endp_q;
  assign frame     = frame_q;
  assign tok_valid = tok_valid_q;
  assign sof_valid = sof_valid_q;
  assign hs_valid  = hs_valid_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;

endmodule

// File: tb/tb_usb_rx_packet.sv
// Randomized bench for usb_rx_packet against a packet-level reference model.
module tb_usb_rx_packet;

  localparam int unsigned MAXP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_error;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frame;
  logic        tok_valid;
  logic        sof_valid;
  logic        hs_valid;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pkt_done;
  logic        pkt_ok;

  always #5 clk = ~clk;

  usb_rx_packet #(.MAX_PAYLOAD(MAXP)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_active (rx_active),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .pid       (pid),
    .addr      (addr),
    .endp      (endp),
    .frame     (frame),
    .tok_valid (tok_valid),
    .sof_valid (sof_valid),
    .hs_valid  (hs_valid),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pkt_done  (pkt_done),
    .pkt_ok    (pkt_ok)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed results, collected away from the active edge.
  logic [7:0] pl_seen[$];
  int         done_cnt = 0;
  logic       done_ok, done_tok, done_sof, done_hs;

  always @(negedge clk) begin
    if (pl_valid) pl_seen.push_back(pl_data);
    if (pkt_done) begin
      done_cnt++;
      done_ok  = pkt_ok;
      done_tok = tok_valid;
      done_sof = sof_valid;
      done_hs  = hs_valid;
    end
  end

  // Expected persistent field outputs.
  logic [3:0]  exp_pid   = '0;
  logic [6:0]  exp_addr  = '0;
  logic [3:0]  exp_endp  = '0;
  logic [10:0] exp_frame = '0;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Field placed in b2[7:3]: inverted CRC5, highest bit transmitted first.
  function automatic logic [4:0] crc5_field(input logic [10:0] bits);
    logic [4:0] r = 5'h1F;
    logic [4:0] t;
    logic       fb;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ bits[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    t = ~r;
    return {t[0], t[1], t[2], t[3], t[4]};
  endfunction

  // Returns {first_crc_byte, second_crc_byte} as they appear on the wire.
  function automatic logic [15:0] crc16_field(input logic [7:0] d[$]);
    logic [15:0] r = 16'hFFFF;
    logic [15:0] t;
    logic        fb;
    foreach (d[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ d[i][j];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    t = ~r;
    return {rev8(t[15:8]), rev8(t[7:0])};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":pid"},       32'(pid), 32'd0);
    check({tag, ":addr"},      32'(addr), 32'd0);
    check({tag, ":endp"},      32'(endp), 32'd0);
    check({tag, ":frame"},     32'(frame), 32'd0);
    check({tag, ":tok_valid"}, 32'(tok_valid), 32'd0);
    check({tag, ":sof_valid"}, 32'(sof_valid), 32'd0);
    check({tag, ":hs_valid"},  32'(hs_valid), 32'd0);
    check({tag, ":pl_data"},   32'(pl_data), 32'd0);
    check({tag, ":pl_valid"},  32'(pl_valid), 32'd0);
    check({tag, ":pkt_done"},  32'(pkt_done), 32'd0);
    check({tag, ":pkt_ok"},    32'(pkt_ok), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // err_after = number of bytes delivered before an rx_error pulse (0: none).
  task automatic drive_pkt(input logic [7:0] bytes[$], input int err_after);
    rx_active = 1'b1;
    tick(1);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (err_after == i + 1) begin
        rx_error = 1'b1;
        tick(1);
        rx_error = 1'b0;
      end
      tick($urandom_range(0, 2));
    end
    tick(1);
    rx_active = 1'b0;
  endtask

  task automatic run_pkt(input string name, input logic [7:0] bytes[$], input int err_after);
    logic [7:0] body[$];
    logic [7:0] pay[$];
    logic [7:0] exp_pl[$];
    logic [7:0] b2;
    logic [3:0] nib;
    logic       exp_ok = 1'b0, exp_tok = 1'b0, exp_sof = 1'b0, exp_hs = 1'b0;
    bit         errd = (err_after > 0);
    int         len, seen, nfwd;

    if (bytes.size() > 0) begin
      nib     = bytes[0][3:0];
      exp_pid = nib;
      for (int i = 1; i < bytes.size(); i++) body.push_back(bytes[i]);
      len = body.size();
      if (bytes[0][7:4] == ~nib) begin
        case (nib)
          4'h1, 4'h9, 4'hD, 4'h5: begin
            if (len == 2 && !errd) begin
              b2 = body[1];
              if (b2[7:3] == crc5_field({b2[2:0], body[0]})) begin
                exp_ok = 1'b1;
                if (nib == 4'h5) begin
                  exp_sof   = 1'b1;
                  exp_frame = {b2[2:0], body[0]};
                end else begin
                  exp_tok  = 1'b1;
                  exp_addr = body[0][6:0];
                  exp_endp = {b2[2:0], body[0][7]};
                end
              end
            end
          end
          4'h2, 4'hA, 4'hE: begin
            exp_ok = (len == 0) && !errd;
            exp_hs = exp_ok;
          end
          4'h3, 4'hB, 4'h7, 4'hF: begin
            seen = errd ? err_after - 1 : len;
            nfwd = seen - 2;
            if (nfwd < 0) nfwd = 0;
            if (nfwd > int'(MAXP)) nfwd = int'(MAXP);
            for (int i = 0; i < nfwd; i++) exp_pl.push_back(body[i]);
            if (!errd && len >= 2 && len - 2 <= int'(MAXP)) begin
              for (int i = 0; i < len - 2; i++) pay.push_back(body[i]);
              exp_ok = ({body[len-2], body[len-1]} == crc16_field(pay));
            end
          end
          default: ;
        endcase
      end
    end

    pl_seen.delete();
    done_cnt = 0;
    done_ok = 1'b0; done_tok = 1'b0; done_sof = 1'b0; done_hs = 1'b0;
    drive_pkt(bytes, err_after);
    for (int t = 0; t < 10 && done_cnt == 0; t++) tick(1);
    tick(3);

    check({name, ":done_cnt"},  32'(done_cnt), 32'd1);
    check({name, ":pkt_ok"},    32'(done_ok), 32'(exp_ok));
    check({name, ":tok_valid"}, 32'(done_tok), 32'(exp_tok));
    check({name, ":sof_valid"}, 32'(done_sof), 32'(exp_sof));
    check({name, ":hs_valid"},  32'(done_hs), 32'(exp_hs));
    check({name, ":pid"},       32'(pid), 32'(exp_pid));
    check({name, ":addr"},      32'(addr), 32'(exp_addr));
    check({name, ":endp"},      32'(endp), 32'(exp_endp));
    check({name, ":frame"},     32'(frame), 32'(exp_frame));
    check({name, ":pl_count"},  32'(pl_seen.size()), 32'(exp_pl.size()));
    for (int i = 0; i < exp_pl.size() && i < pl_seen.size(); i++)
      check({name, ":pl_byte"}, 32'(pl_seen[i]), 32'(exp_pl[i]));
    tick($urandom_range(2, 4));
  endtask

  function automatic logic [3:0] pick_nib(input int kind);
    int s;
    logic [3:0] n;
    case (kind)
      0: begin
        s = $urandom_range(0, 2);
        n = (s == 0) ? 4'h1 : (s == 1) ? 4'h9 : 4'hD;
      end
      1: n = 4'h5;
      2: begin
        s = $urandom_range(0, 2);
        n = (s == 0) ? 4'h2 : (s == 1) ? 4'hA : 4'hE;
      end
      default: begin
        s = $urandom_range(0, 3);
        n = (s == 0) ? 4'h3 : (s == 1) ? 4'hB : (s == 2) ? 4'h7 : 4'hF;
      end
    endcase
    return n;
  endfunction

  task automatic gen_pkt(output logic [7:0] q[$], output int err_after);
    logic [7:0]  pay[$];
    logic [7:0]  b1;
    logic [2:0]  e;
    logic [3:0]  nib;
    logic [15:0] c;
    int          k, r, idx;
    k = $urandom_range(0, 9);
    q = {};
    if (k <= 3) begin
      nib = pick_nib((k == 3) ? 1 : 0);
      b1  = 8'($urandom);
      e   = 3'($urandom);
      q   = {{~nib, nib}, b1, {crc5_field({e, b1}), e}};
    end else if (k == 4) begin
      nib = pick_nib(2);
      q   = {{~nib, nib}};
    end else begin
      nib = pick_nib(3);
      q   = {{~nib, nib}};
      for (int i = 0; i < $urandom_range(0, MAXP + 4); i++) begin
        pay.push_back(8'($urandom));
        q.push_back(pay[i]);
      end
      c = crc16_field(pay);
      q.push_back(c[15:8]);
      q.push_back(c[7:0]);
    end
    r = $urandom_range(0, 9);
    if (r == 0) begin
      idx    = $urandom_range(0, q.size() - 1);
      q[idx] = q[idx] ^ (8'h01 << $urandom_range(0, 7));
    end else if (r == 1 && q.size() > 1) begin
      void'(q.pop_back());
    end else if (r == 2) begin
      q.push_back(8'($urandom));
    end else if (r == 3 && $urandom_range(0, 1) == 0) begin
      q.delete();
    end
    err_after = (q.size() > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, q.size()) : 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int         ea;

    reset = 1'b0; rx_data = '0; rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
    tick(3);
    check_reset_state("reset");
    reset = 1'b1;
    tick(2);

    // Bytes without rx_active are ignored.
    pl_seen.delete();
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom));
      tick(1);
    end
    tick(3);
    check("idle:done_cnt", 32'(done_cnt), 32'd0);
    check("idle:pl_count", 32'(pl_seen.size()), 32'd0);

    q = {8'h2D, 8'h00, 8'h10};
    run_pkt("setup_tok", q, 0);
    q = {8'h2D, 8'h00, 8'h11};
    run_pkt("setup_badcrc", q, 0);
    q = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt("data0_setup", q, 0);
    q = {8'hD2};
    run_pkt("ack", q, 0);
    q = {8'hD3};
    run_pkt("bad_pid", q, 0);
    q = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt("data_rx_error", q, 4);
    q = {};
    run_pkt("empty", q, 0);
    q = {8'h2D, 8'h00};
    run_pkt("short_tok", q, 0);

    // Reset asserted mid-DATA and released while rx_active is still high.
    rx_active = 1'b1;
    tick(1);
    q = {8'hC3, 8'h80, 8'h06, 8'h00};
    foreach (q[i]) begin
      send_byte(q[i]);
      tick(1);
    end
    reset = 1'b0;
    send_byte(8'h01);
    tick(1);
    reset = 1'b1;
    check_reset_state("rst_mid");
    exp_pid = '0; exp_addr = '0; exp_endp = '0; exp_frame = '0;
    pl_seen.delete();
    done_cnt = 0;
    q = {8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    foreach (q[i]) begin
      send_byte(q[i]);
      tick(1);
    end
    rx_active = 1'b0;
    tick(10);
    check("rst_mid:done_cnt", 32'(done_cnt), 32'd0);
    check("rst_mid:pl_count", 32'(pl_seen.size()), 32'd0);
    q = {8'h2D, 8'h00, 8'h10};
    run_pkt("after_reset_tok", q, 0);

    for (int n = 0; n < 300; n++) begin
      gen_pkt(q, ea);
      run_pkt($sformatf("rand%0d", n), q, ea);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
